cfg_scan_loader: RTL and testbench
==================================

// Module: cfg_scan_loader
// PURPOSE
//   Upstream driver of the configuration scan chain. Accepts configuration words on a valid/ready
//   stream, serialises them MSB-first onto scan_in, and qualifies each shift with scan_en.
//   Sits between the bitstream source (host or bus bridge) and the head of the chain of 4-bit
//   scan shift registers. Signals completion once exactly CHAIN_LEN bits have been shifted.
// PARAMETERS
//   WORD_W    8   width of each configuration word; bits per load beat
//   CHAIN_LEN 64  total scan-chain length in bits; must be a multiple of WORD_W (elaboration error otherwise)
// PORTS
//   clk         in   1       single clock; the scan chain shares it
//   rst_n       in   1       asynchronous, active-low reset
//   start       in   1       1-cycle pulse; begins a load from IDLE or DONE
//   abort       in   1       returns to IDLE from any state at the next edge
//   word_data   in   WORD_W  configuration word; the first word lands at the far end of the chain
//   word_valid  in   1       word_data valid
//   word_ready  out  1       loader accepts word_data this cycle
//   scan_in     out  1       serial data to the chain head
//   scan_en     out  1       chain shifts on the next posedge while high
//   busy        out  1       high in LOAD/SHIFT/CRC
//   done        out  1       level; high in DONE until next start/abort
//   err         out  1       level; CRC mismatch (CFG_CRC_EN only); cleared by start/abort
// BEHAVIOUR
//   - Reset: state=IDLE; word_ready, scan_in, scan_en, busy, done, err all 0; counters and buffer 0.
//   - FSM: IDLE -start-> LOAD; LOAD -(valid&ready)-> SHIFT; SHIFT -(WORD_W bits, more remain)-> LOAD;
//     SHIFT -(last bit of chain)-> DONE (or CRC when CFG_CRC_EN); CRC -(valid&ready)-> DONE; DONE -start-> LOAD.
//   - word_ready = 1 only in LOAD (and CRC). Handshake completes on the edge where valid&ready=1;
//     word_data captured into shift buffer. word_valid low in LOAD = stall: scan_en stays 0, chain frozen.
//   - SHIFT: exactly WORD_W cycles, scan_en=1 each, scan_in = buffer MSB; buffer shifts left 1 per cycle.
//     scan_in/scan_en derive from flops only (no combinational path from inputs).
//   - Bit counter width $clog2(CHAIN_LEN+1); word counter counts CHAIN_LEN/WORD_W beats; no wrap:
//     after the final beat the FSM leaves SHIFT, extra words are never accepted (word_ready=0).
//   - Latency, word_valid held high: (CHAIN_LEN/WORD_W)*(WORD_W+1) cycles from first LOAD cycle to done=1
//     (64/8 -> 72 cycles). Total scan_en-high cycles per load = CHAIN_LEN exactly.
//   - start while busy: ignored. start and abort same cycle: abort wins -> IDLE.
//   - abort/reset mid-shift: scan_en drops next cycle, partial chain contents left as-is, done=0, err=0.
// CONFIGURATION
//   CFG_CRC_EN defined: CRC-8, poly x^8+x^2+x+1 (0x07), init 0x00, updated per bit in shift order.
//     After the last chain bit, FSM enters CRC, accepts one extra word; its low 8 bits compared to CRC;
//     mismatch -> err=1 together with done=1. Chain contents not altered by the CRC word (scan_en=0).
//   CFG_CRC_EN undefined: no CRC state or logic; SHIFT goes straight to DONE; err tied 0.
// STRUCTURE
//   Shared package cfg_scan_pkg: state enum (IDLE, LOAD, SHIFT, CRC, DONE), CRC8_POLY=8'h07, CRC8_INIT=8'h00.
//   One sub-module: cfg_crc8_serial (1-bit-per-cycle CRC-8 update, enable + clear), instantiated only under CFG_CRC_EN.
//   Remaining logic (FSM, counters, shift buffer) flat in cfg_scan_loader.
// TESTING  (bench: loader feeding 16 chained 4-bit scan registers = 64 bits, WORD_W=8)
//   1 Reset asserted mid-run -> all outputs 0 immediately (async), state IDLE, word_ready=0.
//   2 start, words 0x01..0x08 with valid always 1 -> chain parallel out = 64'h0102030405060708, done at cycle 72, scan_en high 64 cycles.
//   3 Same load with valid low 5 cycles before word 3 -> identical final chain, done at cycle 77, scan_en=0 during stall.
//   4 start pulsed during SHIFT of word 2 -> ignored; load completes normally, done once.
//   5 abort during SHIFT of word 4 -> scan_en=0 next cycle, busy=0, done=0; new start reloads fully and correctly.
//   6 CFG_CRC_EN: correct CRC word -> done=1, err=0; CRC word XOR 0x01 -> done=1, err=1; next start clears err.

Source files
------------

// File: rtl/cfg_scan_pkg.sv
// Shared types and constants for the configuration scan loader.
// The CRC helper is only exercised when CFG_CRC_EN is defined.
package cfg_scan_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CRC, DONE} state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial CRC-8 step: shift in a single data bit, MSB-first order.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_scan_loader_if.sv
// Configuration word stream (valid/ready) between the bitstream source and the loader.
interface cfg_scan_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/cfg_crc8_serial.sv
// Bit-serial CRC-8 accumulator (poly 0x07), one bit per enabled cycle; clear wins over enable.
module cfg_crc8_serial
  import cfg_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (clear) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/cfg_scan_loader.sv
// Serialises configuration words MSB-first into the scan chain with scan_en qualification.
// Optional CRC-8 trailer check is enabled by defining CFG_CRC_EN.
module cfg_scan_loader
  import cfg_scan_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  cfg_scan_loader_if.slave    word,
  output logic                scan_in,
  output logic                scan_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned BEATS  = CHAIN_LEN / WORD_W;
  localparam int unsigned BIT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned POS_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BEAT_W-1:0] BEATS_C  = BEAT_W'(BEATS);
  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(WORD_W - 1);

  if (CHAIN_LEN % WORD_W != 0) begin : g_len_check
    $error("cfg_scan_loader: CHAIN_LEN must be a multiple of WORD_W");
  end

  state_t            state;
  logic [WORD_W-1:0] sbuf;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BEAT_W-1:0] word_cnt;
  logic [POS_W-1:0]  pos;
  logic              ready_q;
  logic              launch;

  assign launch          = start && (state == IDLE || state == DONE);
  assign word.word_ready = ready_q;
  // The buffer drains to zero after each word, so scan_in idles low.
  assign scan_in         = sbuf[WORD_W-1];

`ifdef CFG_CRC_EN
  logic [7:0] crc_val;

  if (WORD_W < 8) begin : g_crc_width_check
    $error("cfg_scan_loader: CFG_CRC_EN needs WORD_W >= 8");
  end

  cfg_crc8_serial u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (abort || launch),
    .en     (state == SHIFT),
    .bit_in (scan_in),
    .crc    (crc_val)
  );
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      scan_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sbuf     <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      pos      <= '0;
`ifdef CFG_CRC_EN
      err      <= 1'b0;
`endif
    end else if (abort) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      scan_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sbuf     <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      pos      <= '0;
`ifdef CFG_CRC_EN
      err      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            ready_q  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            pos      <= '0;
`ifdef CFG_CRC_EN
            err      <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (word.word_valid && word_cnt != BEATS_C) begin
            state    <= SHIFT;
            ready_q  <= 1'b0;
            scan_en  <= 1'b1;
            sbuf     <= word.word_data;
            word_cnt <= word_cnt + 1'b1;
            pos      <= '0;
          end
        end
        SHIFT: begin
          sbuf    <= sbuf << 1;
          bit_cnt <= bit_cnt + 1'b1;
          pos     <= pos + 1'b1;
          if (pos == LAST_POS) begin
            scan_en <= 1'b0;
            pos     <= '0;
            if (bit_cnt == LAST_BIT) begin
`ifdef CFG_CRC_EN
              state   <= CRC;
              ready_q <= 1'b1;
`else
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              state   <= LOAD;
              ready_q <= 1'b1;
            end
          end
        end
`ifdef CFG_CRC_EN
        CRC: begin
          if (word.word_valid) begin
            state   <= DONE;
            ready_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= (word.word_data[7:0] != crc_val);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Self-checking bench: loader drives a chain of 16 x 4-bit scan registers (64 bits, WORD_W=8).
module tb_cfg_scan_loader;
  import cfg_scan_pkg::*;

`ifdef CFG_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk, rst_n, start, abort;
  logic scan_in, scan_en, busy, done, err;
  int   n_chk  = 0;
  int   n_fail = 0;

  cfg_scan_loader_if #(.WORD_W(8)) wif ();

  cfg_scan_loader #(.WORD_W(8), .CHAIN_LEN(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .word    (wif),
    .scan_in (scan_in),
    .scan_en (scan_en),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // The scan chain under load: 16 four-bit shift registers, seg[0] at the head.
  logic [3:0]  seg [16];
  logic [63:0] chain_out;

  always_ff @(posedge clk) begin
    if (scan_en) begin
      seg[0] <= {seg[0][2:0], scan_in};
      for (int i = 1; i < 16; i++) seg[i] <= {seg[i][2:0], seg[i-1][3]};
    end
  end

  always_comb begin
    chain_out = '0;
    for (int i = 0; i < 16; i++) chain_out[i*4 +: 4] = seg[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: words go out in order, each MSB-first; the first bit ends at the far end.
  function automatic logic [63:0] model_chain(input logic [63:0] words);
    bit q[$];
    logic [63:0] c;
    logic [7:0] w;
    for (int k = 0; k < 8; k++) begin
      w = words[63 - 8*k -: 8];
      for (int b = 7; b >= 0; b--) q.push_back(w[b]);
    end
    c = '0;
    foreach (q[i]) c = {c[62:0], q[i]};
    return c;
  endfunction

  function automatic logic [7:0] model_crc(input logic [63:0] words);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      fb = c[7] ^ words[i];
      c  = (c << 1) ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic int model_lat(input int stall_len);
    return 8 * (8 + 1) + stall_len + (CRC_ON ? 1 : 0);
  endfunction

  // Runs one load; cycle 0 is the first LOAD cycle, latency is the cycle done is first seen.
  task automatic run_load(input logic [63:0] words, input logic [7:0] crc_word,
                          input int stall_word, input int stall_len,
                          input int start_at, input int abort_at,
                          output int lat, output int en_cycles,
                          output bit timed_out, output bit aborted);
    int idx, stalled, cyc, nwords;
    bit hs;
    nwords = CRC_ON ? 9 : 8;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_state", {busy, wif.word_ready, done, err}, 4'b1100);
    idx = 0; stalled = 0; cyc = 0; en_cycles = 0; timed_out = 1'b0; aborted = 1'b0;
    while (!done) begin
      if (cyc >= 400) begin timed_out = 1'b1; break; end
      if (idx == stall_word && stalled < stall_len) begin
        wif.word_valid = 1'b0;
        if (wif.word_ready) begin
          stalled++;
          check("stall_scan_en", scan_en, 1'b0);
        end
      end else if (idx < nwords) begin
        wif.word_valid = 1'b1;
        wif.word_data  = (idx < 8) ? words[63 - 8*idx -: 8] : crc_word;
      end else begin
        wif.word_valid = 1'b0;
      end
      start = (cyc == start_at);
      abort = (cyc == abort_at);
      hs = wif.word_valid && wif.word_ready && !abort;
      if (scan_en) en_cycles++;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
      start = 1'b0;
      if (abort) begin abort = 1'b0; aborted = 1'b1; break; end
    end
    wif.word_valid = 1'b0;
    lat = cyc;
  endtask

  typedef struct {
    logic [63:0] words;
    int          stall_word;
    int          stall_len;
    bit          crc_bad;
    logic [63:0] exp_chain;
    int          exp_lat;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    int lat, en;
    bit to, ab;
    logic [7:0] cw;

    clk = 1'b0; rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    wif.word_valid = 1'b0; wif.word_data = '0;

    vecs[0] = '{64'h0102030405060708, -1, 0, 1'b0, 64'h0102030405060708, model_lat(0)};
    vecs[1] = '{64'h0102030405060708,  2, 5, 1'b1, 64'h0102030405060708, model_lat(5)};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF,  0, 3, 1'b0, 64'hFFFFFFFFFFFFFFFF, model_lat(3)};
    vecs[3] = '{64'hAA55AA5500FF8001,  7, 1, 1'b0, 64'hAA55AA5500FF8001, model_lat(1)};
    for (int i = 4; i < NV; i++) begin
      vecs[i].words      = {$urandom(), $urandom()};
      vecs[i].stall_word = int'($urandom_range(0, 7));
      vecs[i].stall_len  = int'($urandom_range(0, 6));
      vecs[i].crc_bad    = 1'($urandom_range(0, 1));
      vecs[i].exp_chain  = model_chain(vecs[i].words);
      vecs[i].exp_lat    = model_lat(vecs[i].stall_len);
    end

    // Reset values
    #1;
    check("rst_outputs", {wif.word_ready, scan_in, scan_en, busy, done, err}, 6'b0);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a load
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; wif.word_valid = 1'b1; wif.word_data = 8'h5A;
    repeat (20) @(negedge clk);
    check("midrun_active", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {wif.word_ready, scan_in, scan_en, busy, done, err}, 6'b0);
    check("async_rst_state", 64'(dut.state), 64'(IDLE));
    @(negedge clk); rst_n = 1'b1; wif.word_valid = 1'b0;

    // start and abort together: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_same", {busy, wif.word_ready, scan_en}, 3'b000);

    // Table-driven loads
    for (int i = 0; i < NV; i++) begin
      cw = model_crc(vecs[i].words) ^ {7'b0, vecs[i].crc_bad};
      run_load(vecs[i].words, cw, vecs[i].stall_word, vecs[i].stall_len, -1, -1, lat, en, to, ab);
      check($sformatf("v%0d_timeout", i), to, 1'b0);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_scan_en_cycles", i), en, 64);
      check($sformatf("v%0d_chain", i), chain_out, vecs[i].exp_chain);
      check($sformatf("v%0d_done_busy", i), {done, busy}, 2'b10);
      check($sformatf("v%0d_err", i), err, CRC_ON ? vecs[i].crc_bad : 1'b0);
    end

    // In DONE extra words are refused and the chain stays put
    wif.word_valid = 1'b1; wif.word_data = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_no_accept", {wif.word_ready, scan_en, done}, 3'b001);
    end
    check("done_chain_hold", chain_out, vecs[NV-1].exp_chain);
    wif.word_valid = 1'b0;

    // start pulsed while shifting word 2 is ignored
    cw = model_crc(64'h1122334455667788);
    run_load(64'h1122334455667788, cw, -1, 0, 12, -1, lat, en, to, ab);
    check("busy_start_latency", lat, model_lat(0));
    check("busy_start_chain", chain_out, 64'h1122334455667788);
    repeat (2) @(negedge clk);
    check("busy_start_done_held", {done, busy}, 2'b10);

    // abort while shifting word 4
    run_load(64'h0102030405060708, 8'h00, -1, 0, -1, 30, lat, en, to, ab);
    check("abort_taken", ab, 1'b1);
    check("abort_outputs", {scan_en, busy, done, err, wif.word_ready}, 5'b0);
    check("abort_partial_shifts", en, 27);
    cw = model_crc(64'h0102030405060708);
    run_load(64'h0102030405060708, cw, -1, 0, -1, -1, lat, en, to, ab);
    check("reload_latency", lat, model_lat(0));
    check("reload_chain", chain_out, 64'h0102030405060708);
    check("reload_done_err", {done, err}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
